// File: rtl/seq_pkg.sv
// Shared definitions for instr_sequencer: opcodes, FSM encoding, instruction field positions.
package seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LOAD = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BEQZ = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_BEQZ) && (op < OP_HALT);
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer; non-ALU opcodes yield zero.
module seq_alu
  import seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller driving an 8x16 register file, with a handshaked LOAD path.
// Optional SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_data,
  output logic [2:0]         rf_read_addr1,
  output logic [2:0]         rf_read_addr2,
  input  logic [DATA_W-1:0]  rf_read_data1,
  input  logic [DATA_W-1:0]  rf_read_data2,
  output logic [2:0]         rf_write_addr,
  output logic               rf_write_en,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_rd_en,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  output logic               halted,
  output logic               illegal_op
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   result;
  logic [DMEM_AW-1:0]  mem_addr;

  logic [3:0]          op;
  logic [8:0]          imm9;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     target;
  logic [DATA_W-1:0]   alu_y;
  logic [DATA_W-1:0]   exec_val;

  assign op     = ir[OP_HI:OP_LO];
  assign imm9   = ir[IMM_HI:IMM_LO];
  assign pc_inc = pc + PC_W'(1);
  assign target = PC_W'(imm9);

  // BEQZ tests rd, so operand 1 is steered to the rd field for it.
  assign rf_read_addr1 = (op == OP_BEQZ) ? ir[RD_HI:RD_LO] : ir[RS1_HI:RS1_LO];
  assign rf_read_addr2 = ir[RS2_HI:RS2_LO];

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op),
    .a  (rf_read_data1),
    .b  (rf_read_data2),
    .y  (alu_y)
  );

  assign exec_val = (op == OP_LDI) ? DATA_W'(imm9) : alu_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      result   <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= imem_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= exec_val;
          if (is_alu_op(op) || op == OP_LDI) begin
            state <= S_WB;
          end else if (op == OP_LOAD) begin
            // Latched so the address stays put for the whole handshake.
            mem_addr <= rf_read_data1[DMEM_AW-1:0];
            state    <= S_MEM;
          end else if (op == OP_HALT) begin
            state <= S_HALT;
          end else begin
            if (op == OP_JMP)
              pc <= target;
            else if (op == OP_BEQZ && rf_read_data1 == '0)
              pc <= target;
            else
              pc <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            result <= dmem_rdata;
            state  <= S_WB;
          end
        end
        S_WB: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign imem_addr     = pc;
  assign rf_write_en   = (state == S_WB);
  assign rf_write_addr = ir[RD_HI:RD_LO];
  assign rf_write_data = result;
  assign dmem_addr     = mem_addr;
  assign dmem_rd_en    = (state == S_MEM);
  assign halted        = (state == S_HALT);
  assign illegal_op    = (state == S_EXEC) && is_illegal(op);

`ifdef SEQ_RETIRE_CNT_EN
  logic retire_evt;

  assign retire_evt = (state == S_WB) ||
                      ((state == S_EXEC) && !is_alu_op(op) && op != OP_LDI &&
                       op != OP_LOAD && op != OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= '0;
    else if (retire_evt)
      retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level model predicts writes, pulses and halt timing.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic [2:0]  rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic [15:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic        rf_write_en;
  logic [7:0]  dmem_addr;
  logic        dmem_rd_en;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        halted, illegal_op;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .rf_write_addr(rf_write_addr), .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
    .dmem_addr(dmem_addr), .dmem_rd_en(dmem_rd_en), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .halted(halted), .illegal_op(illegal_op)
`ifdef SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int cyc; logic [2:0] addr; logic [15:0] data; } ev_t;
  typedef struct { logic [7:0] addr; int lat; logic [15:0] data; } ld_t;

  ev_t         q[$];
  ld_t         dq[$];
  logic [15:0] rom [256];
  logic [15:0] rf [8];
  logic [15:0] mreg [8];
  logic        rf_load = 1'b1;
  int          n_cmp = 0, n_bad = 0;
  int          cyc;
  int          ld_cnt = 0;
  bit          halt_seen = 0;
  int          halt_pc;
  logic [15:0] exp_retire;
  int          force_lat = 0;
  logic [15:0] force_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Register file and ROM models
  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];
  always @(negedge clk) begin
    if (rf_load) for (int i = 0; i < 8; i++) rf[i] <= 16'(i);
    else if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
  end
  always @(posedge clk) imem_data <= rom[imem_addr];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  // Data memory: ready on the lat-th request cycle; random ready noise when idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      dmem_ready = 1'b0;
      ld_cnt = 0;
    end else if (dmem_rd_en) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dmem_req: got request at %0h expected none", dmem_addr);
        dmem_ready = 1'b0;
      end else begin
        ld_cnt++;
        chk("dmem_addr", dmem_addr, dq[0].addr);
        if (ld_cnt == dq[0].lat) begin
          dmem_ready = 1'b1;
          dmem_rdata = dq[0].data;
          void'(dq.pop_front());
          ld_cnt = 0;
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = 16'($urandom);
        end
      end
    end else begin
      dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = 16'($urandom);
      ld_cnt = 0;
    end
  end

  task automatic pop_chk(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("ev_kind", 64'(kind), 64'(e.kind));
      chk("ev_cycle", 64'(cyc), 64'(e.cyc));
      if (kind == 0 && e.kind == 0) begin
        chk("wr_addr", rf_write_addr, e.addr);
        chk("wr_data", rf_write_data, e.data);
      end
    end
  endtask

  // Monitor: kind 0 = register write, 1 = illegal pulse, 2 = halt entry
  always @(negedge clk) begin
    if (!rst_n) halt_seen = 0;
    else begin
      if (rf_write_en) pop_chk(0);
      if (illegal_op) pop_chk(1);
      if (halted && !halt_seen) begin
        halt_seen = 1;
        pop_chk(2);
      end
    end
  end

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'd0};
  endfunction
  function automatic logic [15:0] enci(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 9'(imm)};
  endfunction

  // Instruction-level reference: walks the program, records expected events with their cycle.
  task automatic iss();
    int t = 0, pc = 0, steps = 0, rd, rs1, rs2, lat;
    logic [15:0] w, v, imm;
    logic [3:0] op;
    bit done = 0;
    exp_retire = '0;
    for (int i = 0; i < 8; i++) mreg[i] = 16'(i);
    while (!done && steps < 400) begin
      w = rom[pc]; op = w[15:12]; rd = int'(w[11:9]); rs1 = int'(w[8:6]);
      rs2 = int'(w[5:3]); imm = {7'd0, w[8:0]};
      steps++;
      if ((op >= 1 && op <= 5) || op == 7) begin
        case (op)
          4'd1: v = mreg[rs1] + mreg[rs2];
          4'd2: v = mreg[rs1] - mreg[rs2];
          4'd3: v = mreg[rs1] & mreg[rs2];
          4'd4: v = mreg[rs1] | mreg[rs2];
          4'd5: v = mreg[rs1] ^ mreg[rs2];
          default: v = imm;
        endcase
        mreg[rd] = v;
        q.push_back('{kind: 0, cyc: t + 3, addr: 3'(rd), data: v});
        t += 4; pc = (pc + 1) % 256; exp_retire++;
      end else if (op == 6) begin
        lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
        v = (force_lat != 0) ? force_data : 16'($urandom);
        dq.push_back('{addr: mreg[rs1][7:0], lat: lat, data: v});
        mreg[rd] = v;
        q.push_back('{kind: 0, cyc: t + 3 + lat, addr: 3'(rd), data: v});
        t += 4 + lat; pc = (pc + 1) % 256; exp_retire++;
      end else if (op == 15) begin
        q.push_back('{kind: 2, cyc: t + 3, addr: 3'd0, data: 16'd0});
        halt_pc = pc; done = 1;
      end else begin
        if (op >= 10) q.push_back('{kind: 1, cyc: t + 2, addr: 3'd0, data: 16'd0});
        if (op == 8) pc = int'(imm) % 256;
        else if (op == 9 && mreg[rd] == 16'd0) pc = int'(imm) % 256;
        else pc = (pc + 1) % 256;
        t += 3; exp_retire++;
      end
    end
  endtask

  task automatic start_reset();
    rst_n = 1'b0; rf_load = 1'b1;
    q.delete(); dq.delete();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_prog(input string tag);
    iss();
    #1;
    chk({tag, "_rst_outs"}, {imem_addr, rf_read_addr1, rf_read_addr2, rf_write_addr, rf_write_en,
        rf_write_data, dmem_addr, dmem_rd_en, halted, illegal_op}, 64'd0);
`ifdef SEQ_RETIRE_CNT_EN
    chk({tag, "_rst_retire"}, retire_cnt, 64'd0);
`endif
    rf_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk({tag, "_first_fetch"}, imem_addr, 64'd0);
    for (int i = 0; i < 3000 && !halt_seen; i++) @(negedge clk);
    #1;
    chk({tag, "_halt_reached"}, 64'(halt_seen), 64'd1);
    chk({tag, "_events_left"}, 64'(q.size()), 64'd0);
    chk({tag, "_loads_left"}, 64'(dq.size()), 64'd0);
`ifdef SEQ_RETIRE_CNT_EN
    chk({tag, "_retire"}, retire_cnt, exp_retire);
`endif
    repeat (3) @(negedge clk);
    #1 chk({tag, "_halt_frozen"}, {imem_addr, halted, dmem_rd_en}, {8'(halt_pc), 1'b1, 1'b0});
  endtask

  initial begin
    // Program 1: LDI/LDI/ADD/HALT
    start_reset();
    rom[0] = enci(7, 1, 5); rom[1] = enci(7, 2, 3); rom[2] = enc(1, 3, 1, 2);
    run_prog("p1");
    chk("p1_r3", rf[3], 16'd8);

    // Program 2: SUB wrap, 3-cycle LOAD, taken/not-taken BEQZ, illegal, JMP at 0xFF
    start_reset();
    rom[8'h00] = enci(9, 7, 8'h50);
    rom[8'h01] = enc(2, 4, 0, 1);
    rom[8'h02] = enci(7, 2, 8'h12);
    rom[8'h03] = enc(6, 5, 2, 0);
    rom[8'h04] = enci(9, 0, 8'h20);
    rom[8'h20] = enci(9, 1, 8'h30);
    rom[8'h21] = 16'hC000;
    rom[8'h22] = enci(7, 7, 0);
    rom[8'h23] = enci(8, 0, 8'hFF);
    rom[8'hFF] = enci(8, 0, 9'h100);
    force_lat = 3; force_data = 16'hBEEF;
    run_prog("p2");
    force_lat = 0;
    chk("p2_r4", rf[4], 16'hFFFF);
    chk("p2_r5", rf[5], 16'hBEEF);

    // Program 3: sequential fetch past 0xFF wraps to 0
    start_reset();
    rom[8'h00] = enci(9, 6, 8'h10);
    rom[8'h01] = enci(8, 0, 8'hFE);
    rom[8'hFE] = enci(7, 6, 0);
    rom[8'hFF] = enc(5, 3, 1, 2);
    run_prog("p3");
    chk("p3_r3", rf[3], 16'd3);

    // Reset during MEM abandons the load
    start_reset();
    rom[0] = enc(6, 5, 3, 0);
    dq.push_back('{addr: 8'h03, lat: 10, data: 16'h1234});
    rf_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !dmem_rd_en; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 chk("mrst_pre_rd_en", dmem_rd_en, 1'b1);
    rst_n = 1'b0;
    #1 chk("mrst_outs", {dmem_rd_en, rf_write_en, imem_addr, halted}, 64'd0);
    repeat (2) @(negedge clk);
    #1 chk("mrst_no_write", rf[5], 16'd5);

    // Randomized programs with forward-only control flow so they always halt
    for (int p = 0; p < 8; p++) begin
      start_reset();
      for (int a = 0; a < 40; a++) begin
        int op;
        op = int'($urandom_range(0, 14));
        if (op == 8 || op == 9)
          rom[a] = enci(op, int'($urandom_range(0, 7)), int'($urandom_range(a + 1, 40)));
        else
          rom[a] = {4'(op), 12'($urandom)};
      end
      run_prog("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller directly upstream of the 8x16 register file.
- Drives the register file's two read addresses, write address, write enable and write data; consumes its two read-data buses.
- Fetches 16-bit instructions from a synchronous instruction ROM and services LOAD through a variable-latency data-memory handshake.
- Contains the ALU.

Parameters:
- PC_W, 8: program counter width; instruction ROM depth is 2^PC_W.
- DATA_W, 16: register and data-memory word width.
- DMEM_AW, 8: data-memory address width, taken from the low bits of the rs1 value.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  PC_W  instruction ROM address.
- imem_data  in  16  ROM data, valid one cycle after imem_addr.
- rf_read_addr1  out  3  register file operand-1 address.
- rf_read_addr2  out  3  register file operand-2 address.
- rf_read_data1  in  DATA_W  register file operand 1, combinational.
- rf_read_data2  in  DATA_W  register file operand 2, combinational.
- rf_write_addr  out  3  destination register.
- rf_write_en  out  1  register write strobe.
- rf_write_data  out  DATA_W  writeback value.
- dmem_addr  out  DMEM_AW  load address.
- dmem_rd_en  out  1  load request, level.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready=1.
- dmem_ready  in  1  load complete.
- halted  out  1  sticky halt indicator.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
Instruction word: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9.

Opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2
- 6 LOAD: rd <= dmem[rs1[DMEM_AW-1:0]]
- 7 LDI: rd <= zero-extend(imm9)
- 8 JMP: pc <= imm9[PC_W-1:0]
- 9 BEQZ: if reg[rd]==0 then pc <= imm9, else pc+1
- 15 HALT
- 10-14: illegal; treated as NOP, with illegal_op pulsed in EXEC.

FSM states:
- FETCH: imem_addr=pc. Next state DECODE.
- DECODE: ir <= imem_data at the end of the cycle. Next state EXEC.
- EXEC:
  - rf_read_addr1 = ir[11:9] for BEQZ, otherwise ir[8:6]; rf_read_addr2 = ir[5:3].
  - result register latched from the ALU.
  - ALU ops and LDI go to WB. LOAD goes to MEM.
  - JMP, BEQZ, NOP and illegal update pc and go to FETCH.
  - HALT goes to HALT_ST.
- MEM:
  - dmem_rd_en=1 and dmem_addr stable, held until dmem_ready=1.
  - On ready: result <= dmem_rdata, go to WB.
  - dmem_ready outside MEM is ignored.
- WB: rf_write_en=1 for exactly one cycle, rf_write_addr=ir[11:9], rf_write_data=result; pc <= pc+1; go to FETCH.
- HALT_ST: halted=1; stays until reset; no memory or register activity.

Latency:
- ALU/LDI: 4 cycles.
- LOAD: 4+N cycles, where N>=1 is the number of MEM cycles up to and including the ready cycle.
- JMP/BEQZ/NOP: 3 cycles.

Arithmetic and widths:
- ADD/SUB are modulo 2^DATA_W; carry and borrow are discarded.
- pc increments wrap from 2^PC_W-1 to 0.
- Branch targets are truncated to PC_W bits.

Write timing: write outputs are held stable for the whole WB cycle, so a negedge-writing register file captures them mid-cycle.

Reset (asynchronous, any state):
- state=FETCH, pc=0, ir=0 (NOP), result=0.
- All outputs 0; halted=0.
- dmem_rd_en drops immediately, even mid-MEM; an outstanding load is abandoned.

Optional Feature:
Macro SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (16 bits), reset to 0. It increments on each transition out of WB and on each EXEC-to-FETCH transition for JMP/BEQZ/NOP/illegal, and wraps at 0xFFFF. HALT is not counted.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package seq_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT)
  - the state encoding enum
  - instruction field bit-position constants
- One sub-module, seq_alu: combinational, op plus two DATA_W operands in, DATA_W result out. Used in EXEC.
- FSM, pc, ir and handshake logic stay in instr_sequencer.

Test Plan:
- Reset then program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT (rf model preloaded ri=i) -> r3=8, rf_write_en pulses exactly 3 times, halted=1 at cycle 15, pc frozen.
- SUB r4,r0,r1 with r0=0, r1=1 -> r4=0xFFFF (wrap).
- LOAD r5,[r2] with r2=0x0012, dmem returning 0xBEEF after 3 wait cycles -> dmem_addr=0x12 held while dmem_rd_en=1 for 3 cycles, r5=0xBEEF, instruction takes 7 cycles.
- BEQZ r0,0x20 with r0=0 -> next imem_addr=0x20; BEQZ r1,0x20 with r1=1 -> next imem_addr=pc+1; JMP at pc=0xFF to 0 and sequential fetch past 0xFF -> both continue at 0x00.
- Opcode 0xC -> illegal_op high for exactly one cycle, no register write, pc+1.
- rst_n low during MEM -> dmem_rd_en falls asynchronously, no write occurs; after release, fetch restarts at imem_addr=0. With SEQ_RETIRE_CNT_EN, the first program gives retire_cnt=3.
